// File: rtl/rule_serializer.sv
// rule_serializer
// Turns 64-bit beats of packed 16-bit rule-ID lanes into a stream of one
// rule ID per cycle. Every packet ends in exactly one record flagged last:
// either its final rule ID or, if it carried no rules, a single no-match
// record with ID 0. One ID is held back in a pending register so the last
// flag is exact even when the packet's final beat has no rules in it.
module rule_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int RULE_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [2:0]            in_empty,
    output logic                  in_ready,
    output logic [RULE_W-1:0]     out_rule_id,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  out_nomatch,
    input  logic                  out_ready,
    output logic [31:0]           rule_cnt,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           nomatch_cnt
);

    localparam int NUM_LANES = DATA_WIDTH / RULE_W;

    // Framing comes from in_eop alone; sop and empty carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{in_sop, in_empty};

    // Beat register
    logic                              beat_valid;
    logic                              beat_eop;
    logic [NUM_LANES-1:0]              mask;
    logic [NUM_LANES-1:0][RULE_W-1:0]  lanes;

    // Pending (lookahead) register
    logic                              pend_valid;
    logic [RULE_W-1:0]                 pend_id;

    // Scan decode
    logic                              accept;
    logic [NUM_LANES-1:0]              in_mask;
    logic [NUM_LANES-1:0]              low_bit;
    logic                              has_lane;
    logic [RULE_W-1:0]                 sel_id;
    logic                              push_ok;
    logic                              push;
    logic [RULE_W-1:0]                 push_id;
    logic                              push_last;
    logic                              push_nomatch;
    logic                              take_lane;
    logic                              clr_pend;
    logic                              drop_beat;
    logic                              fire;

    assign in_ready = rst_n & ~beat_valid;
    assign accept   = in_valid & in_ready;
    assign push_ok  = ~out_valid | out_ready;
    assign has_lane = |mask;
    assign low_bit  = mask & (~mask + NUM_LANES'(1));
    assign fire     = out_valid & out_ready;

    // Occupancy mask of an incoming beat: a lane is live when its ID is nonzero.
    always_comb begin
        in_mask = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            in_mask[k] = |in_data[RULE_W*k +: RULE_W];
        end
    end

    // Lane mux driven by the one-hot lowest live lane.
    always_comb begin
        sel_id = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (low_bit[k]) begin
                sel_id = sel_id | lanes[k];
            end
        end
    end

    // Scan step: decide what moves between beat, pend and output this cycle.
    always_comb begin
        push         = 1'b0;
        push_id      = '0;
        push_last    = 1'b0;
        push_nomatch = 1'b0;
        take_lane    = 1'b0;
        clr_pend     = 1'b0;
        drop_beat    = 1'b0;
        if (beat_valid) begin
            if (has_lane) begin
                if (pend_valid) begin
                    // Shift pend out and refill it from the next live lane.
                    if (push_ok) begin
                        push      = 1'b1;
                        push_id   = pend_id;
                        take_lane = 1'b1;
                    end
                end else begin
                    // Filling an empty pend never touches the output register.
                    take_lane = 1'b1;
                end
            end else if (beat_eop) begin
                if (push_ok) begin
                    push      = 1'b1;
                    push_last = 1'b1;
                    clr_pend  = 1'b1;
                    drop_beat = 1'b1;
                    if (pend_valid) begin
                        push_id = pend_id;
                    end else begin
                        push_nomatch = 1'b1;
                    end
                end
            end else begin
                // Mid-packet beat exhausted; pend carries over to the next beat.
                drop_beat = 1'b1;
            end
        end
    end

    // Beat register: load on accept, retire lanes as they move into pend.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_valid <= 1'b0;
            beat_eop   <= 1'b0;
            mask       <= '0;
            lanes      <= '0;
        end else if (accept) begin
            beat_valid <= 1'b1;
            beat_eop   <= in_eop;
            mask       <= in_mask;
            lanes      <= in_data;
        end else begin
            if (take_lane) begin
                mask <= mask & ~low_bit;
            end
            if (drop_beat) begin
                beat_valid <= 1'b0;
            end
        end
    end

    // Pending register: one-record lookahead that makes out_last exact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_id    <= '0;
        end else if (take_lane) begin
            pend_valid <= 1'b1;
            pend_id    <= sel_id;
        end else if (clr_pend) begin
            pend_valid <= 1'b0;
            pend_id    <= '0;
        end
    end

    // Output register: load on push, otherwise hold until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_rule_id <= '0;
            out_last    <= 1'b0;
            out_nomatch <= 1'b0;
        end else if (push) begin
            out_valid   <= 1'b1;
            out_rule_id <= push_id;
            out_last    <= push_last;
            out_nomatch <= push_nomatch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Statistics on records accepted downstream; free-running wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rule_cnt    <= '0;
            pkt_cnt     <= '0;
            nomatch_cnt <= '0;
        end else if (fire) begin
            if (!out_nomatch) begin
                rule_cnt <= rule_cnt + 32'd1;
            end
            if (out_last) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (out_nomatch) begin
                nomatch_cnt <= nomatch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rule_serializer.sv
// tb_rule_serializer
// Randomized and directed stimulus against a packet-level reference model:
// each packet's expected records are its nonzero lane IDs in order, last on
// the final one, or a single no-match record when it has none.
module tb_rule_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [2:0]  in_empty = '0;
    logic        in_ready;
    logic [15:0] out_rule_id;
    logic        out_valid;
    logic        out_last;
    logic        out_nomatch;
    logic        out_ready = 1'b0;
    logic [31:0] rule_cnt;
    logic [31:0] pkt_cnt;
    logic [31:0] nomatch_cnt;

    rule_serializer #(.DATA_WIDTH(64), .RULE_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_empty    (in_empty),
        .in_ready    (in_ready),
        .out_rule_id (out_rule_id),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_nomatch (out_nomatch),
        .out_ready   (out_ready),
        .rule_cnt    (rule_cnt),
        .pkt_cnt     (pkt_cnt),
        .nomatch_cnt (nomatch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        eop;
    } beat_t;

    typedef struct {
        logic [15:0] id;
        logic        last;
        logic        nm;
    } rec_t;

    beat_t       bq[$];
    rec_t        eq[$];
    logic [15:0] pkt_ids[$];

    int n_tests = 0;
    int n_fail  = 0;
    int m_rule  = 0;
    int m_pkt   = 0;
    int m_nm    = 0;
    int valid_mode = 1;
    int ready_mode = 1;
    int pat = 0;
    int cyc = 0;
    int pops = 0;
    int first_pop = 0;
    int last_pop = 0;
    bit accepted_now = 1'b0;
    bit stall_prev = 1'b0;
    logic [18:0] stall_rec = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        logic [15:0] la, lb, lc, ld;
        la = a[15:0];
        lb = b[15:0];
        lc = c[15:0];
        ld = d[15:0];
        return {ld, lc, lb, la};
    endfunction

    // Queue a beat for the driver and extend the reference model.
    task automatic add_beat(input logic [63:0] d, input logic eop);
        beat_t b;
        rec_t  r;
        b.data = d;
        b.eop  = eop;
        bq.push_back(b);
        for (int k = 0; k < 4; k++) begin
            if (d[16*k +: 16] != 16'd0) pkt_ids.push_back(d[16*k +: 16]);
        end
        if (eop) begin
            if (pkt_ids.size() == 0) begin
                r.id = 16'd0; r.last = 1'b1; r.nm = 1'b1;
                eq.push_back(r);
            end else begin
                for (int i = 0; i < pkt_ids.size(); i++) begin
                    r.id = pkt_ids[i];
                    r.last = (i == pkt_ids.size() - 1);
                    r.nm = 1'b0;
                    eq.push_back(r);
                end
            end
            pkt_ids.delete();
        end
    endtask

    // One cycle: drive inputs at negedge, then score what the next posedge will accept.
    task automatic step();
        rec_t r;
        @(negedge clk);
        cyc++;
        in_valid = (bq.size() > 0) && (valid_mode == 1 || $urandom_range(0, 2) != 0);
        if (bq.size() > 0) begin
            in_data = bq[0].data;
            in_eop  = bq[0].eop;
        end else begin
            in_data = '0;
            in_eop  = 1'b0;
        end
        in_sop = 1'($urandom_range(0, 1));
        case (ready_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = (pat % 3 == 0);
            default: out_ready = 1'b1;
        endcase
        pat++;
        if (stall_prev)
            chk("stall_hold", {45'd0, out_valid, out_rule_id, out_last, out_nomatch}, {45'd0, stall_rec});
        if (out_valid && out_ready) begin
            if (eq.size() == 0) begin
                chk("extra_record", {48'd0, out_rule_id}, 64'hffff_ffff);
            end else begin
                r = eq.pop_front();
                chk("record", {46'd0, out_rule_id, out_last, out_nomatch}, {46'd0, r.id, r.last, r.nm});
                if (!r.nm) m_rule++;
                if (r.last) m_pkt++;
                if (r.nm) m_nm++;
                pops++;
                if (pops == 1) first_pop = cyc;
                last_pop = cyc;
            end
        end
        stall_prev = out_valid && !out_ready;
        stall_rec  = {1'b1, out_rule_id, out_last, out_nomatch};
        accepted_now = in_valid && in_ready;
        if (accepted_now) void'(bq.pop_front());
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((bq.size() > 0 || eq.size() > 0 || out_valid) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 64'd1, 64'd0);
        repeat (4) step();
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_rule_cnt"}, {32'd0, rule_cnt}, 64'(m_rule));
        chk({tag, "_pkt_cnt"}, {32'd0, pkt_cnt}, 64'(m_pkt));
        chk({tag, "_nomatch_cnt"}, {32'd0, nomatch_cnt}, 64'(m_nm));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_out", {45'd0, out_valid, out_rule_id, out_last, out_nomatch}, 64'd0);
        chk("rst_counters", {rule_cnt | pkt_cnt | nomatch_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        bq.delete();
        eq.delete();
        pkt_ids.delete();
        m_rule = 0; m_pkt = 0; m_nm = 0;
        stall_prev = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid is first seen.
    task automatic latency(input string tag, input logic [63:0] d, input int exp_lat);
        int n = 0;
        valid_mode = 1;
        ready_mode = 1;
        add_beat(d, 1'b1);
        accepted_now = 1'b0;
        while (!accepted_now && n < 10) begin step(); n++; end
        if (!accepted_now) chk({tag, "_accept_timeout"}, 64'd1, 64'd0);
        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < 10);
        chk(tag, 64'(n), 64'(exp_lat));
        drain(50);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // No-match packet: latency 2, counters.
        latency("lat_nomatch", pack4(0, 0, 0, 0), 2);
        check_counts("t1");

        // One-rule packet: latency 3.
        latency("lat_one_rule", pack4(0, 0, 6, 0), 3);

        // Lanes after a zero lane, back-to-back emission.
        do_reset();
        pops = 0;
        add_beat(pack4(5, 0, 9, 7), 1'b1);
        drain(50);
        chk("t2_b2b", 64'(last_pop - first_pop), 64'd2);
        check_counts("t2");

        // Trailing all-zero eop beat.
        add_beat(pack4(3, 4, 0, 0), 1'b0);
        add_beat(pack4(0, 0, 0, 0), 1'b1);
        drain(50);
        check_counts("t3");

        // Stalled output: ready 1,0,0,1,...
        ready_mode = 2;
        pat = 0;
        add_beat(pack4(5, 0, 9, 7), 1'b1);
        drain(100);
        check_counts("t4");

        // Back-to-back packets.
        ready_mode = 1;
        add_beat(pack4(1, 2, 3, 4), 1'b1);
        add_beat(pack4(0, 0, 0, 0), 1'b1);
        add_beat(pack4(8, 0, 0, 0), 1'b1);
        drain(100);
        check_counts("t5");

        // Reset in the middle of a packet.
        do_reset();
        pops = 0;
        add_beat(pack4(1, 2, 3, 4), 1'b1);
        begin
            int n = 0;
            while (pops < 2 && n < 30) begin step(); n++; end
            if (pops < 2) chk("t6_timeout", 64'd1, 64'd0);
        end
        do_reset();
        add_beat(pack4(16'h11, 0, 0, 16'h22), 1'b1);
        drain(50);
        check_counts("t6");

        // Randomized packets with random valid gaps and backpressure.
        valid_mode = 0;
        ready_mode = 0;
        for (int p = 0; p < 150; p++) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                logic [63:0] d;
                d = '0;
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 1) == 1) d[16*k +: 16] = 16'($urandom_range(1, 65535));
                end
                add_beat(d, b == nb - 1);
            end
        end
        drain(20000);
        check_counts("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
